input_debounce_interface: RTL and testbench
===========================================

INPUT_DEBOUNCE_INTERFACE -- requirements
Module: input_debounce_interface

Parameters
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 100000 (1 ms at 100 MHz), legal range 2..2^20-1, meaning the number of consecutive cycles a synchronized input must hold a new value before it is accepted.

Interface
REQ-002 The block SHALL have port clock, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port switch0, input, 1 bit: raw, asynchronous write-block select (0 = block 1, 1 = block 2).
REQ-005 The block SHALL have port switch1, input, 1 bit: raw, asynchronous read-block select (0 = block 1, 1 = block 2).
REQ-006 The block SHALL have port button, input, 1 bit: raw, asynchronous pushbutton (1 = pressed).
REQ-007 The block SHALL have port write_block, output, 1 bit: debounced switch0 level.
REQ-008 The block SHALL have port read_block, output, 1 bit: debounced switch1 level.
REQ-009 The block SHALL have port button_level, output, 1 bit: debounced button level.
REQ-010 The block SHALL have port write_changed, output, 1 bit: one-cycle pulse when write_block changes.
REQ-011 The block SHALL have port read_changed, output, 1 bit: one-cycle pulse when read_block changes.
REQ-012 The block SHALL have port button_press, output, 1 bit: one-cycle pulse on the 0->1 transition of button_level only.

Function
REQ-013 Each raw input SHALL pass through its own 2-flop synchronizer before any other logic.
REQ-014 Channels (switch0, switch1, button) SHALL be independent, each with its own counter (ceil(log2(DEBOUNCE_CYCLES)) bits) and 2-state FSM.
REQ-015 In FSM state STABLE, the counter SHALL be 0; when sync != stable value, the FSM SHALL go to TESTING with counter = 1.
REQ-016 In state TESTING, while sync != stable value, the counter SHALL increment by 1 per cycle.
REQ-017 In state TESTING, if sync == stable value (glitch), the FSM SHALL return to STABLE with counter = 0 and no output change.
REQ-018 When the counter equals DEBOUNCE_CYCLES-1 and sync still differs, on the next edge the stable value SHALL invert, the channel pulse SHALL assert for exactly 1 cycle, and the FSM SHALL go to STABLE with counter = 0.
REQ-019 Latency: a clean raw transition SHALL appear on the level output exactly DEBOUNCE_CYCLES+2 rising edges after the first edge that samples the new raw value, with the pulse in that same cycle.
REQ-020 The counter SHALL never wrap; it saturates into the accept transition in REQ-018.
REQ-021 Changes on different channels in the same cycle SHALL each be processed and pulsed independently, with no priority between them.
REQ-022 button_press SHALL NOT assert on a button release; write_changed and read_changed SHALL assert on both edges.
REQ-023 Every output SHALL be driven directly from a flop, with no combinational path from inputs to outputs.

Reset
REQ-024 While reset = 1, all synchronizer flops, stable values, counters and outputs SHALL be 0, and all FSMs SHALL be in STABLE.
REQ-025 Reset asserted mid-TESTING SHALL abort the pending transition with no pulse.
REQ-026 An input held at 1 through reset release SHALL debounce normally after release, producing its level change and pulse at the REQ-019 latency.

Verification (DEBOUNCE_CYCLES = 4 on the bench)
REQ-027 The bench SHALL check: reset for 3 cycles with all raw inputs at 0 -> all outputs 0 throughout and for 20 cycles after release.
REQ-028 The bench SHALL check: switch0 0->1 held -> write_block = 1 and write_changed = 1 for one cycle, exactly 6 edges after first sample; switch0 1->0 -> same, write_block = 0.
REQ-029 The bench SHALL check: switch1 pulsed high for 3 cycles, then low -> read_block stays 0 and read_changed is never asserted.
REQ-030 The bench SHALL check: button held high for 10 cycles then released -> button_press exactly one pulse at edge 6, button_level 1 then 0, with no pulse on release.
REQ-031 The bench SHALL check: switch0 and button rise in the same cycle -> write_changed and button_press pulse in the same cycle.
REQ-032 The bench SHALL check: switch1 rises, reset asserted after 3 cycles for 1 cycle with switch1 still 1 -> no pulse before reset, then read_block = 1 and read_changed pulse 6 edges after reset release.

Source files
------------

// File: rtl/input_debounce_interface.sv
// Three-channel debouncer for two slide switches and a pushbutton. Each raw input is
// synchronized, then accepted only after holding a new value for DEBOUNCE_CYCLES cycles.

module debounce_channel #(
  parameter int DEBOUNCE_CYCLES = 100000,
  parameter bit RISE_ONLY       = 1'b0
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_raw,
  output logic o_level,
  output logic o_pulse
);
  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] LP_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {ST_STABLE = 1'b0, ST_TESTING = 1'b1} state_t;

  logic          r_sync1;
  logic          r_sync2;
  state_t        r_state;
  logic [CW-1:0] r_count;
  logic          r_stable;
  logic          r_pulse;

  state_t        w_state_nxt;
  logic [CW-1:0] w_count_nxt;
  logic          w_stable_nxt;
  logic          w_pulse_nxt;
  logic          w_differs;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state  <= ST_STABLE;
      r_count  <= '0;
      r_stable <= 1'b0;
      r_pulse  <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_count  <= w_count_nxt;
      r_stable <= w_stable_nxt;
      r_pulse  <= w_pulse_nxt;
    end
  end

  assign w_differs = (r_sync2 != r_stable);

  always_comb begin
    w_state_nxt  = r_state;
    w_count_nxt  = r_count;
    w_stable_nxt = r_stable;
    w_pulse_nxt  = 1'b0;
    case (r_state)
      ST_STABLE: begin
        w_count_nxt = '0;
        if (w_differs) begin
          w_state_nxt = ST_TESTING;
          w_count_nxt = CW'(1);
        end
      end
      ST_TESTING: begin
        if (!w_differs) begin
          w_state_nxt = ST_STABLE;
          w_count_nxt = '0;
        end else if (r_count == LP_LAST) begin
          // Accept: the counter never wraps, it lands here instead.
          w_state_nxt  = ST_STABLE;
          w_count_nxt  = '0;
          w_stable_nxt = ~r_stable;
          w_pulse_nxt  = RISE_ONLY ? ~r_stable : 1'b1;
        end else begin
          w_count_nxt = r_count + 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_STABLE;
        w_count_nxt = '0;
      end
    endcase
  end

  assign o_level = r_stable;
  assign o_pulse = r_pulse;
endmodule

module input_debounce_interface #(
  parameter int DEBOUNCE_CYCLES = 100000
) (
  input  logic clock,
  input  logic reset,
  input  logic switch0,
  input  logic switch1,
  input  logic button,
  output logic write_block,
  output logic read_block,
  output logic button_level,
  output logic write_changed,
  output logic read_changed,
  output logic button_press
);
  debounce_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .RISE_ONLY(1'b0)) u_switch0 (
    .i_clock(clock), .i_reset(reset), .i_raw(switch0),
    .o_level(write_block), .o_pulse(write_changed)
  );

  debounce_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .RISE_ONLY(1'b0)) u_switch1 (
    .i_clock(clock), .i_reset(reset), .i_raw(switch1),
    .o_level(read_block), .o_pulse(read_changed)
  );

  // The button only reports presses; releases update the level silently.
  debounce_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .RISE_ONLY(1'b1)) u_button (
    .i_clock(clock), .i_reset(reset), .i_raw(button),
    .o_level(button_level), .o_pulse(button_press)
  );
endmodule

// File: tb/tb_input_debounce_interface.sv
// Bench for input_debounce_interface: directed scenarios plus random input bursts,
// every cycle compared against a run-length reference model.

module tb_input_debounce_interface;
  localparam int DB = 4;

  logic clock = 1'b0;
  logic reset;
  logic switch0, switch1, button;
  logic write_block, read_block, button_level;
  logic write_changed, read_changed, button_press;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state: two-deep sample delay, accepted level, run length.
  bit m_d1[3], m_d2[3], m_stable[3], m_pulse[3];
  int m_run[3];
  logic [5:0] exp_q[$];

  int w_first[3], w_cnt[3];
  bit w_lvl_hi[3];

  input_debounce_interface #(.DEBOUNCE_CYCLES(DB)) dut (
    .clock(clock), .reset(reset), .switch0(switch0), .switch1(switch1), .button(button),
    .write_block(write_block), .read_block(read_block), .button_level(button_level),
    .write_changed(write_changed), .read_changed(read_changed), .button_press(button_press)
  );

  always #5 clock = ~clock;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_edge();
    bit raw[3];
    raw[0] = switch0;
    raw[1] = switch1;
    raw[2] = button;
    for (int c = 0; c < 3; c++) begin
      bit seen;
      m_pulse[c] = 1'b0;
      if (reset) begin
        m_d1[c] = 0; m_d2[c] = 0; m_stable[c] = 0; m_run[c] = 0;
      end else begin
        seen    = m_d2[c];
        m_d2[c] = m_d1[c];
        m_d1[c] = raw[c];
        if (seen != m_stable[c]) m_run[c]++;
        else m_run[c] = 0;
        if (m_run[c] == DB) begin
          m_stable[c] = ~m_stable[c];
          m_run[c]    = 0;
          m_pulse[c]  = (c == 2) ? m_stable[c] : 1'b1;
        end
      end
    end
    exp_q.push_back({m_stable[0], m_stable[1], m_stable[2], m_pulse[0], m_pulse[1], m_pulse[2]});
  endtask

  task automatic step();
    @(posedge clock);
    model_edge();
    #1;
    check_val("outputs{wb,rb,bl,wc,rc,bp}",
              {26'd0, write_block, read_block, button_level, write_changed, read_changed, button_press},
              {26'd0, exp_q.pop_front()});
  endtask

  task automatic watch(input int n);
    bit p[3], l[3];
    for (int c = 0; c < 3; c++) begin
      w_first[c] = -1; w_cnt[c] = 0; w_lvl_hi[c] = 0;
    end
    for (int i = 1; i <= n; i++) begin
      step();
      p[0] = write_changed; p[1] = read_changed; p[2] = button_press;
      l[0] = write_block;   l[1] = read_block;   l[2] = button_level;
      for (int c = 0; c < 3; c++) begin
        if (l[c]) w_lvl_hi[c] = 1;
        if (p[c]) begin
          w_cnt[c]++;
          if (w_first[c] == -1) w_first[c] = i;
        end
      end
    end
  endtask

  initial begin
    reset = 1'b1; switch0 = 0; switch1 = 0; button = 0;

    // Reset held with idle inputs, then quiet period.
    watch(3);
    reset = 1'b0;
    watch(20);
    check_val("idle_pulses", w_cnt[0] + w_cnt[1] + w_cnt[2], 0);
    check_val("idle_levels", {w_lvl_hi[0], w_lvl_hi[1], w_lvl_hi[2]}, 3'b000);

    // switch0 rise and fall.
    switch0 = 1;
    watch(12);
    check_val("sw0_rise_edge", w_first[0], 6);
    check_val("sw0_rise_count", w_cnt[0], 1);
    check_val("sw0_rise_level", write_block, 1);
    switch0 = 0;
    watch(12);
    check_val("sw0_fall_edge", w_first[0], 6);
    check_val("sw0_fall_count", w_cnt[0], 1);
    check_val("sw0_fall_level", write_block, 0);

    // switch1 glitch shorter than the debounce window.
    switch1 = 1;
    watch(3);
    switch1 = 0;
    watch(5);
    check_val("sw1_glitch_pulse", w_cnt[1], 0);
    check_val("sw1_glitch_level", w_lvl_hi[1], 0);
    watch(10);
    check_val("sw1_glitch_late_pulse", w_cnt[1], 0);

    // Button press held 10 cycles then released.
    button = 1;
    watch(10);
    check_val("btn_press_edge", w_first[2], 6);
    check_val("btn_press_count", w_cnt[2], 1);
    check_val("btn_level_high", button_level, 1);
    button = 0;
    watch(12);
    check_val("btn_release_pulse", w_cnt[2], 0);
    check_val("btn_level_low", button_level, 0);

    // Simultaneous switch0 and button rise.
    switch0 = 1; button = 1;
    watch(10);
    check_val("sim_wc_edge", w_first[0], 6);
    check_val("sim_bp_edge", w_first[2], 6);
    switch0 = 0; button = 0;
    watch(10);

    // switch1 rise interrupted by reset, input held through release.
    switch1 = 1;
    watch(3);
    check_val("rst_abort_pre_pulse", w_cnt[1], 0);
    reset = 1'b1;
    watch(1);
    check_val("rst_abort_in_reset", w_cnt[1], 0);
    reset = 1'b0;
    watch(12);
    check_val("rst_release_edge", w_first[1], 6);
    check_val("rst_release_count", w_cnt[1], 1);
    check_val("rst_release_level", read_block, 1);

    // Random bursts with occasional resets.
    for (int seg = 0; seg < 60; seg++) begin
      switch0 = $urandom_range(0, 1);
      switch1 = $urandom_range(0, 1);
      button  = $urandom_range(0, 1);
      reset   = ($urandom_range(0, 15) == 0);
      watch(1);
      reset = 1'b0;
      watch($urandom_range(0, 8));
    end
    watch(10);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
